// File: rtl/intr_sched_pkg.sv
// Shared PDP-8/e major-state encodings, interrupt-scheduler IOT codes and FSM states.
package intr_sched_pkg;

  typedef enum logic [3:0] {
    F0, F1, F2, F3,
    D0, D1, D2, D3,
    E0, E1, E2, E3,
    H0, H1, H2, H3
  } major_state_t;

  localparam logic [5:0]  IOT_DEV = 6'o11;
  localparam logic [0:11] IOT_LMK = {3'o6, IOT_DEV, 3'o1};
  localparam logic [0:11] IOT_RMK = {3'o6, IOT_DEV, 3'o2};
  localparam logic [0:11] IOT_RPV = {3'o6, IOT_DEV, 3'o3};
  localparam logic [0:11] IOT_SPI = {3'o6, IOT_DEV, 3'o4};

  typedef enum logic [1:0] {
    SCH_IDLE,
    SCH_ARMED,
    SCH_ACK,
    SCH_RUN
  } sched_state_t;

endpackage

// File: rtl/intr_sched_if.sv
// Device request/acknowledge lines plus the IOT data path of the interrupt scheduler.
interface intr_sched_if #(parameter int unsigned NDEV = 8);
  logic [NDEV-1:0] dev_irq;
  logic [NDEV-1:0] dev_ack;
  logic [0:11]     instruction;
  logic [0:11]     mdout;
  logic [0:11]     rac;
  logic [0:11]     me_bus;
  logic            mskip;

  modport master (output dev_irq, instruction, mdout, rac,
                  input  dev_ack, me_bus, mskip);
  modport slave  (input  dev_irq, instruction, mdout, rac,
                  output dev_ack, me_bus, mskip);
endinterface

// File: rtl/intr_sched_prio_enc8.sv
// Lowest-index-wins priority encoder over eight request bits.
module prio_enc8 (
  input  logic [7:0] req,
  output logic [2:0] vec,
  output logic       any
);
  logic found;

  always_comb begin
    vec   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (req[i] && !found) begin
        vec   = 3'(i);
        found = 1'b1;
      end
    end
    any = |req;
  end
endmodule

// File: rtl/intr_sched.sv
// PDP-8/e interrupt scheduler: request sync/mask, interrupt-cycle FSM, device-11 IOTs.
module intr_sched
  import intr_sched_pkg::*;
#(
  parameter int unsigned NDEV = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic [3:0]    state,
  input  logic          instr_done,
  input  logic          int_ena,
  input  logic          int_inh,
  intr_sched_if.slave   bus,
  output logic          irq,
  output logic          int_in_prog
);

  logic [NDEV-1:0] sync1, sync2, pend;
  logic [7:0]      mask, pend8, ack8;
  logic [2:0]      vec, gvec;
  logic            any, gvalid;
  sched_state_t    sch, sch_nxt;

  assign pend = sync2 & mask[NDEV-1:0];

  always_comb begin
    pend8            = '0;
    pend8[NDEV-1:0]  = pend;
  end

  prio_enc8 u_prio (
    .req (pend8),
    .vec (vec),
    .any (any)
  );

  always_comb begin
    sch_nxt = sch;
    unique case (sch)
      SCH_IDLE:  if (instr_done && int_ena && !int_inh && irq) sch_nxt = SCH_ARMED;
      SCH_ARMED: if (state == E0) sch_nxt = SCH_ACK;
      SCH_ACK:   sch_nxt = SCH_RUN;
      SCH_RUN:   if (state == E3) sch_nxt = SCH_IDLE;
      default:   sch_nxt = SCH_IDLE;
    endcase
  end

  // Outputs decode straight from the state register, so they are glitch-free
  // and ACK lasts exactly one clock.
  always_comb begin
    int_in_prog = (sch != SCH_IDLE);
    ack8        = (sch == SCH_ACK && gvalid) ? (8'h01 << gvec) : '0;
    bus.dev_ack = ack8[NDEV-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sch    <= SCH_IDLE;
      gvec   <= '0;
      gvalid <= 1'b0;
    end else if (clear) begin
      sch    <= SCH_IDLE;
      gvalid <= 1'b0;
    end else begin
      sch <= sch_nxt;
      if (sch == SCH_IDLE && sch_nxt == SCH_ARMED) begin
        gvec   <= vec;
        gvalid <= any;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1      <= '0;
      sync2      <= '0;
      irq        <= 1'b0;
      mask       <= '1;
      bus.mskip  <= 1'b0;
      bus.me_bus <= '0;
    end else if (clear) begin
      sync1     <= '0;
      sync2     <= '0;
      irq       <= 1'b0;
      mask      <= '1;
      bus.mskip <= 1'b0;
    end else begin
      sync1 <= bus.dev_irq;
      sync2 <= sync1;
      irq   <= |pend;
      if (state == F1 && bus.mdout == IOT_SPI && irq) bus.mskip <= 1'b1;
      if (state == F3) bus.mskip <= 1'b0;
      if (state == F3 && bus.instruction == IOT_LMK) mask <= bus.rac[4:11];
      if (state == F2 && bus.instruction == IOT_RMK) bus.me_bus <= {4'o0, mask};
      if (state == F2 && bus.instruction == IOT_RPV) bus.me_bus <= bus.rac | {9'o0, vec};
    end
  end

endmodule

// File: tb/tb_intr_sched.sv
// Directed self-checking bench for intr_sched.
module tb_intr_sched;
  import intr_sched_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic [3:0] state;
  logic       instr_done, int_ena, int_inh;
  logic       irq, int_in_prog;
  int         vectors = 0;
  int         miscompares = 0;

  intr_sched_if #(.NDEV(8)) bus ();

  intr_sched #(.NDEV(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .state       (state),
    .instr_done  (instr_done),
    .int_ena     (int_ena),
    .int_inh     (int_inh),
    .bus         (bus.slave),
    .irq         (irq),
    .int_in_prog (int_in_prog)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; clear = 1'b0; state = D0; instr_done = 1'b0;
    int_ena = 1'b1; int_inh = 1'b0;
    bus.dev_irq = 8'h04; bus.instruction = '0; bus.mdout = '0; bus.rac = '0;
    tick(2);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL rst_irq got %b exp 0", irq); end
    vectors++; if (int_in_prog !== 1'b0) begin miscompares++; $display("FAIL rst_iip got %b exp 0", int_in_prog); end
    vectors++; if (bus.dev_ack !== 8'h00) begin miscompares++; $display("FAIL rst_ack got %h exp 00", bus.dev_ack); end
    vectors++; if (bus.mskip !== 1'b0) begin miscompares++; $display("FAIL rst_mskip got %b exp 0", bus.mskip); end
    vectors++; if (bus.me_bus !== 12'o0000) begin miscompares++; $display("FAIL rst_me_bus got %o exp 0000", bus.me_bus); end
    reset = 1'b1;
    tick(2);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_lat2 got %b exp 0", irq); end
    tick();
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_lat3 got %b exp 1", irq); end
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    vectors++; if (int_in_prog !== 1'b1) begin miscompares++; $display("FAIL arm_iip got %b exp 1", int_in_prog); end
    state = E0; tick();
    vectors++; if (bus.dev_ack !== 8'h04) begin miscompares++; $display("FAIL ack_dev2 got %h exp 04", bus.dev_ack); end
    bus.dev_irq = 8'h00;
    state = E1; tick();
    vectors++; if (bus.dev_ack !== 8'h00) begin miscompares++; $display("FAIL ack_width got %h exp 00", bus.dev_ack); end
    vectors++; if (int_in_prog !== 1'b1) begin miscompares++; $display("FAIL run_iip got %b exp 1", int_in_prog); end
    state = E3; tick();
    vectors++; if (int_in_prog !== 1'b0) begin miscompares++; $display("FAIL e3_iip got %b exp 0", int_in_prog); end
    state = D0; tick(3);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_fall got %b exp 0", irq); end
  endtask

  task automatic test_priority;
    bus.dev_irq = 8'h28;
    tick(3);
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL prio_irq got %b exp 1", irq); end
    bus.instruction = IOT_RPV; bus.rac = 12'o0000; state = F2; tick();
    vectors++; if (bus.me_bus !== 12'o0003) begin miscompares++; $display("FAIL rpv got %o exp 0003", bus.me_bus); end
    bus.instruction = '0; bus.mdout = IOT_SPI; state = F1; tick();
    vectors++; if (bus.mskip !== 1'b1) begin miscompares++; $display("FAIL spi_skip got %b exp 1", bus.mskip); end
    bus.mdout = '0; state = F3; tick();
    vectors++; if (bus.mskip !== 1'b0) begin miscompares++; $display("FAIL f3_mskip got %b exp 0", bus.mskip); end
    state = D0; instr_done = 1'b1; tick();
    instr_done = 1'b0;
    vectors++; if (int_in_prog !== 1'b1) begin miscompares++; $display("FAIL prio_iip got %b exp 1", int_in_prog); end
    // requests vanish after arming; the latched device must still be acked
    bus.dev_irq = 8'h00;
    state = E0; tick();
    vectors++; if (bus.dev_ack !== 8'h08) begin miscompares++; $display("FAIL ack_dev3 got %h exp 08", bus.dev_ack); end
    state = E1; tick();
    state = E3; tick();
    vectors++; if (int_in_prog !== 1'b0) begin miscompares++; $display("FAIL prio_done got %b exp 0", int_in_prog); end
    state = D0; tick(3);
  endtask

  task automatic test_mask;
    bus.instruction = IOT_LMK; bus.rac = 12'o0367; state = F3; tick();
    bus.instruction = '0; bus.rac = '0; state = D0;
    bus.dev_irq = 8'h08;
    tick(4);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL masked_irq got %b exp 0", irq); end
    bus.mdout = IOT_SPI; state = F1; tick();
    vectors++; if (bus.mskip !== 1'b0) begin miscompares++; $display("FAIL masked_spi got %b exp 0", bus.mskip); end
    bus.mdout = '0; bus.instruction = IOT_RMK; state = F2; tick();
    vectors++; if (bus.me_bus !== 12'o0367) begin miscompares++; $display("FAIL rmk got %o exp 0367", bus.me_bus); end
    bus.instruction = '0; state = D0; tick();
    vectors++; if (bus.me_bus !== 12'o0367) begin miscompares++; $display("FAIL me_bus_hold got %o exp 0367", bus.me_bus); end
    bus.dev_irq = 8'h00;
    tick();
  endtask

  task automatic test_inhibit;
    bus.dev_irq = 8'h01;
    tick(3);
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL inh_irq got %b exp 1", irq); end
    int_inh = 1'b1; instr_done = 1'b1; tick();
    instr_done = 1'b0;
    vectors++; if (int_in_prog !== 1'b0) begin miscompares++; $display("FAIL inh_iip got %b exp 0", int_in_prog); end
    state = E0; tick();
    vectors++; if (bus.dev_ack !== 8'h00) begin miscompares++; $display("FAIL inh_ack got %h exp 00", bus.dev_ack); end
    int_inh = 1'b0; state = D0; instr_done = 1'b1; tick();
    instr_done = 1'b0;
    vectors++; if (int_in_prog !== 1'b1) begin miscompares++; $display("FAIL uninh_iip got %b exp 1", int_in_prog); end
    state = E0; tick();
    vectors++; if (bus.dev_ack !== 8'h01) begin miscompares++; $display("FAIL ack_dev0 got %h exp 01", bus.dev_ack); end
    bus.dev_irq = 8'h00;
    state = E1; tick();
    state = E3; tick();
    vectors++; if (int_in_prog !== 1'b0) begin miscompares++; $display("FAIL inh_done got %b exp 0", int_in_prog); end
    state = D0; tick(3);
  endtask

  task automatic test_clear;
    bus.dev_irq = 8'h02;
    tick(3);
    instr_done = 1'b1; tick();
    instr_done = 1'b0;
    vectors++; if (int_in_prog !== 1'b1) begin miscompares++; $display("FAIL clr_armed got %b exp 1", int_in_prog); end
    clear = 1'b1; tick();
    clear = 1'b0;
    vectors++; if (int_in_prog !== 1'b0) begin miscompares++; $display("FAIL clr_iip got %b exp 0", int_in_prog); end
    state = E0; tick();
    vectors++; if (bus.dev_ack !== 8'h00) begin miscompares++; $display("FAIL clr_ack got %h exp 00", bus.dev_ack); end
    bus.instruction = IOT_RMK; state = F2; tick();
    vectors++; if (bus.me_bus !== 12'o0377) begin miscompares++; $display("FAIL clr_mask got %o exp 0377", bus.me_bus); end
    bus.instruction = '0; state = D0; bus.dev_irq = 8'h00;
    tick(4);
  endtask

  task automatic test_sync_pulse;
    bus.dev_irq = 8'h02; tick();
    bus.dev_irq = 8'h00; tick(5);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL pulse_decay got %b exp 0", irq); end
    bus.dev_irq = 8'h02;
    tick(2);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL hold_lat2 got %b exp 0", irq); end
    tick();
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL hold_lat3 got %b exp 1", irq); end
    bus.dev_irq = 8'h00;
    tick(2);
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL fall_lat2 got %b exp 1", irq); end
    tick();
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL fall_lat3 got %b exp 0", irq); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_mask();
    test_inhibit();
    test_clear();
    test_sync_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
